elevator_scheduler: RTL and testbench
=====================================

ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 Parameter NUM_FLOORS, default 10, number of served floors (2..2**FLOOR_WIDTH).
REQ-002 Parameter FLOOR_WIDTH, default 4, width of floor index.
REQ-003 Parameter TRAVEL_CYCLES, default 8, clock cycles to move one floor (>=1).
REQ-004 Parameter DOOR_CYCLES, default 16, clock cycles door stays open after last hold (>=1).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 floor_requests  input  NUM_FLOORS  pending-request bitmap from the request register; bit i = floor i pending.
REQ-008 door_hold  input  1  obstruction/hold-door button; level-sensitive.
REQ-009 current_floor  output  FLOOR_WIDTH  registered cab position.
REQ-010 clear_current_request  output  1  clears floor_requests[current_floor] in the request register.
REQ-011 moving_up / moving_down  output  1 each  motor commands; never both high.
REQ-012 door_open  output  1  door command.
REQ-013 dir_up  output  1  registered travel preference (1 = up).

Function
REQ-014 FSM states: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN; all outputs are decodes of registered state.
REQ-015 Derived terms: req_here = floor_requests[current_floor]; req_above = any bit > current_floor; req_below = any bit < current_floor.
REQ-016 IDLE decision priority: req_here -> DOOR_OPEN; else req_above and (dir_up or !req_below) -> MOVE_UP, dir_up=1; else req_below -> MOVE_DOWN, dir_up=0; else stay IDLE, dir_up unchanged.
REQ-017 MOVE_x: travel counter loaded TRAVEL_CYCLES-1 on entry, decrements each cycle; on the cycle it reads 0, current_floor steps +/-1 at that edge.
REQ-018 At arrival edge, decision uses the new floor: request there -> DOOR_OPEN; else requests further in same direction -> remain MOVE_x with counter reloaded; else IDLE.
REQ-019 current_floor shall never go below 0 nor above NUM_FLOORS-1; MOVE_UP at top floor or MOVE_DOWN at floor 0 shall fall to IDLE without stepping.
REQ-020 DOOR_OPEN: door counter loaded DOOR_CYCLES-1 on entry; door_hold high reloads it; exit to IDLE on the cycle counter is 0 and door_hold low.
REQ-021 clear_current_request high on every DOOR_OPEN cycle including the last, so requests for the current floor arriving while the door is open are absorbed.
REQ-022 moving_up high only in MOVE_UP, moving_down only in MOVE_DOWN, door_open only in DOOR_OPEN; current_floor constant outside the arrival edge.
REQ-023 Pass-through latency: request bit visible in IDLE -> state change on next edge; no combinational path from inputs to outputs.
REQ-024 Requests changing mid-travel are honoured at the next arrival decision; a cab never reverses between floors.

Reset
REQ-025 reset_n low: state IDLE, current_floor 0, dir_up 1, both counters 0, all command outputs 0, immediately and asynchronously.
REQ-026 Reset asserted mid-move or mid-door aborts the operation; no clear pulse is emitted on release.

Structure
REQ-027 Shared package elevator_pkg holds the state encoding (2-bit IDLE=0, MOVE_UP=1, MOVE_DOWN=2, DOOR_OPEN=3) and default timing constants.
REQ-028 One combinational sub-module floor_request_scan computes req_here/req_above/req_below from bitmap and current_floor.
REQ-029 Counters sized $clog2 of the larger of TRAVEL_CYCLES, DOOR_CYCLES, minimum 1 bit.

Verification (bench uses TRAVEL_CYCLES=4, DOOR_CYCLES=6, scheduler looped with the request register)
REQ-030 Reset release, no requests -> IDLE, floor 0, all commands 0 for 20 cycles.
REQ-031 Floor 0, request floor 3 -> moving_up 12 cycles, floor reads 3, door_open 6 cycles, clear high those 6 cycles, bit 3 cleared, IDLE.
REQ-032 Floor 5 moving up, requests 7 and 2 -> services 7 first, then reverses and services 2; no reversal between floors.
REQ-033 IDLE at floor 4, request floor 4 -> door_open next edge, no motor command, bit cleared.
REQ-034 door_hold held 10 cycles inside DOOR_OPEN -> door stays open; after release closes exactly 6 cycles later.
REQ-035 reset_n pulsed low mid-travel between floors 2 and 3 -> floor 0, IDLE, moving_up 0 immediately.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared state encoding, default timing constants and counter sizing for the elevator scheduler.
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_DOOR_OPEN = 2'd3
  } state_e;

  localparam int DEF_NUM_FLOORS    = 10;
  localparam int DEF_FLOOR_WIDTH   = 4;
  localparam int DEF_TRAVEL_CYCLES = 8;
  localparam int DEF_DOOR_CYCLES   = 16;

  // Width holding max(travel, door) - 1, never narrower than one bit.
  function automatic int cnt_width(input int travel, input int door);
    int m;
    m = (travel > door) ? travel : door;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/floor_request_scan.sv
// Combinational scan of the pending-request bitmap relative to a reference floor.
module floor_request_scan #(
  parameter int NUM_FLOORS  = 10,
  parameter int FLOOR_WIDTH = 4
) (
  input  logic [NUM_FLOORS-1:0]  floor_requests,
  input  logic [FLOOR_WIDTH-1:0] ref_floor,
  output logic                   req_here,
  output logic                   req_above,
  output logic                   req_below
);

  logic [31:0] ref_ext;

  assign ref_ext = 32'(ref_floor);

  always_comb begin
    req_here  = 1'b0;
    req_above = 1'b0;
    req_below = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (i == ref_ext) begin
        req_here = req_here | floor_requests[i];
      end else if (i > ref_ext) begin
        req_above = req_above | floor_requests[i];
      end else begin
        req_below = req_below | floor_requests[i];
      end
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// Single-cab elevator scheduler: collective up/down sweep with timed travel and door dwell.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
  parameter int FLOOR_WIDTH   = DEF_FLOOR_WIDTH,
  parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
  parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_FLOORS-1:0]  floor_requests,
  input  logic                   door_hold,
  output logic [FLOOR_WIDTH-1:0] current_floor,
  output logic                   clear_current_request,
  output logic                   moving_up,
  output logic                   moving_down,
  output logic                   door_open,
  output logic                   dir_up
);

  localparam int CNT_W = cnt_width(TRAVEL_CYCLES, DOOR_CYCLES);
  localparam logic [CNT_W-1:0]       TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0]       DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_WIDTH-1:0] TOP_FLOOR   = FLOOR_WIDTH'(NUM_FLOORS - 1);

  state_e                 state_q, state_d;
  logic [FLOOR_WIDTH-1:0] floor_q, floor_d;
  logic                   dir_up_q, dir_up_d;
  logic [CNT_W-1:0]       travel_cnt_q, travel_cnt_d;
  logic [CNT_W-1:0]       door_cnt_q, door_cnt_d;

  logic [FLOOR_WIDTH-1:0] arrive_floor;
  logic                   req_here, req_above, req_below;
  logic                   arr_here, arr_above, arr_below;

  // Floor the cab would land on this edge; the arrival decision is scanned against it.
  always_comb begin
    arrive_floor = floor_q;
    if (state_q == ST_MOVE_UP && floor_q != TOP_FLOOR) begin
      arrive_floor = floor_q + 1'b1;
    end else if (state_q == ST_MOVE_DOWN && floor_q != '0) begin
      arrive_floor = floor_q - 1'b1;
    end
  end

  floor_request_scan #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_WIDTH(FLOOR_WIDTH)
  ) u_scan_here (
    .floor_requests(floor_requests),
    .ref_floor     (floor_q),
    .req_here      (req_here),
    .req_above     (req_above),
    .req_below     (req_below)
  );

  floor_request_scan #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_WIDTH(FLOOR_WIDTH)
  ) u_scan_arrive (
    .floor_requests(floor_requests),
    .ref_floor     (arrive_floor),
    .req_here      (arr_here),
    .req_above     (arr_above),
    .req_below     (arr_below)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      floor_q      <= '0;
      dir_up_q     <= 1'b1;
      travel_cnt_q <= '0;
      door_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      dir_up_q     <= dir_up_d;
      travel_cnt_q <= travel_cnt_d;
      door_cnt_q   <= door_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    floor_d      = floor_q;
    dir_up_d     = dir_up_q;
    travel_cnt_d = travel_cnt_q;
    door_cnt_d   = door_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_here) begin
          state_d    = ST_DOOR_OPEN;
          door_cnt_d = DOOR_LOAD;
        end else if (req_above && (dir_up_q || !req_below)) begin
          state_d      = ST_MOVE_UP;
          dir_up_d     = 1'b1;
          travel_cnt_d = TRAVEL_LOAD;
        end else if (req_below) begin
          state_d      = ST_MOVE_DOWN;
          dir_up_d     = 1'b0;
          travel_cnt_d = TRAVEL_LOAD;
        end
      end
      ST_MOVE_UP: begin
        if (floor_q == TOP_FLOOR) begin
          state_d = ST_IDLE;
        end else if (travel_cnt_q == '0) begin
          floor_d = arrive_floor;
          if (arr_here) begin
            state_d    = ST_DOOR_OPEN;
            door_cnt_d = DOOR_LOAD;
          end else if (arr_above) begin
            travel_cnt_d = TRAVEL_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          travel_cnt_d = travel_cnt_q - 1'b1;
        end
      end
      ST_MOVE_DOWN: begin
        if (floor_q == '0) begin
          state_d = ST_IDLE;
        end else if (travel_cnt_q == '0) begin
          floor_d = arrive_floor;
          if (arr_here) begin
            state_d    = ST_DOOR_OPEN;
            door_cnt_d = DOOR_LOAD;
          end else if (arr_below) begin
            travel_cnt_d = TRAVEL_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          travel_cnt_d = travel_cnt_q - 1'b1;
        end
      end
      ST_DOOR_OPEN: begin
        if (door_hold) begin
          door_cnt_d = DOOR_LOAD;
        end else if (door_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          door_cnt_d = door_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign current_floor         = floor_q;
  assign dir_up                = dir_up_q;
  assign moving_up             = (state_q == ST_MOVE_UP);
  assign moving_down           = (state_q == ST_MOVE_DOWN);
  assign door_open             = (state_q == ST_DOOR_OPEN);
  assign clear_current_request = (state_q == ST_DOOR_OPEN);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Self-checking bench: scheduler looped with a request register, checked against a floor-level reference model.
module tb_elevator_scheduler;

  localparam int NF = 10;
  localparam int TC = 4;
  localparam int DC = 6;

  typedef enum int {M_IDLE, M_UP, M_DOWN, M_DOOR} mmode_e;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NF-1:0] new_req = '0;
  logic          door_hold = 1'b0;
  logic [NF-1:0] req_q;
  logic [NF-1:0] req_nxt;
  logic [3:0]    current_floor;
  logic          clear_current_request, moving_up, moving_down, door_open, dir_up;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  elevator_scheduler #(
    .NUM_FLOORS   (NF),
    .FLOOR_WIDTH  (4),
    .TRAVEL_CYCLES(TC),
    .DOOR_CYCLES  (DC)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .floor_requests       (req_q),
    .door_hold            (door_hold),
    .current_floor        (current_floor),
    .clear_current_request(clear_current_request),
    .moving_up            (moving_up),
    .moving_down          (moving_down),
    .door_open            (door_open),
    .dir_up               (dir_up)
  );

  // Request register: new calls are OR-ed in, the cab's clear wipes its current floor.
  always_comb begin
    req_nxt = req_q | new_req;
    if (clear_current_request) req_nxt[current_floor] = 1'b0;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) req_q <= '0;
    else          req_q <= req_nxt;
  end

  // Reference model: floor position, sweep direction and cycles spent in the current segment.
  mmode_e m_mode, n_mode;
  int     m_floor, n_floor, m_seg, n_seg;
  bit     m_dir, n_dir;

  function automatic bit any_in(input logic [NF-1:0] r, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) if (i >= 0 && i < NF && r[i] === 1'b1) return 1'b1;
    return 1'b0;
  endfunction

  always_comb begin
    n_mode  = m_mode;
    n_floor = m_floor;
    n_dir   = m_dir;
    n_seg   = m_seg;
    case (m_mode)
      M_IDLE: begin
        if (any_in(req_q, m_floor, m_floor)) begin
          n_mode = M_DOOR; n_seg = 0;
        end else if (any_in(req_q, m_floor + 1, NF - 1) && (m_dir || !any_in(req_q, 0, m_floor - 1))) begin
          n_mode = M_UP; n_dir = 1'b1; n_seg = 0;
        end else if (any_in(req_q, 0, m_floor - 1)) begin
          n_mode = M_DOWN; n_dir = 1'b0; n_seg = 0;
        end
      end
      M_UP: begin
        if (m_floor == NF - 1) n_mode = M_IDLE;
        else if (m_seg + 1 == TC) begin
          n_floor = m_floor + 1; n_seg = 0;
          if (any_in(req_q, m_floor + 1, m_floor + 1)) n_mode = M_DOOR;
          else if (!any_in(req_q, m_floor + 2, NF - 1)) n_mode = M_IDLE;
        end else n_seg = m_seg + 1;
      end
      M_DOWN: begin
        if (m_floor == 0) n_mode = M_IDLE;
        else if (m_seg + 1 == TC) begin
          n_floor = m_floor - 1; n_seg = 0;
          if (any_in(req_q, m_floor - 1, m_floor - 1)) n_mode = M_DOOR;
          else if (!any_in(req_q, 0, m_floor - 2)) n_mode = M_IDLE;
        end else n_seg = m_seg + 1;
      end
      M_DOOR: begin
        if (door_hold) n_seg = 0;
        else if (m_seg == DC - 1) n_mode = M_IDLE;
        else n_seg = m_seg + 1;
      end
      default: n_mode = M_IDLE;
    endcase
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode <= M_IDLE; m_floor <= 0; m_dir <= 1'b1; m_seg <= 0;
    end else begin
      m_mode <= n_mode; m_floor <= n_floor; m_dir <= n_dir; m_seg <= n_seg;
    end
  end

  logic [8:0] obs_v, exp_v;
  assign obs_v = {current_floor, moving_up, moving_down, door_open, clear_current_request, dir_up};
  assign exp_v = {4'(m_floor), m_mode == M_UP, m_mode == M_DOWN, m_mode == M_DOOR, m_mode == M_DOOR, m_dir};

  localparam logic [8:0] IDLE_FLOOR0 = 9'b0000_0000_1;

  task automatic test_reset();
    reset_n = 1'b0; new_req = '0; door_hold = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs_v !== IDLE_FLOOR0) begin fails++; $display("FAIL reset_hold dut=%b want=%b", obs_v, IDLE_FLOOR0); end
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (obs_v !== IDLE_FLOOR0 || obs_v !== exp_v)
        begin fails++; $display("FAIL reset_idle c=%0d dut=%b want=%b", c, obs_v, IDLE_FLOOR0); end
    end
  endtask

  task automatic test_up_to_3();
    int mu = 0, dn = 0, cl = 0;
    bit done = 0;
    new_req = 10'(1) << 3; @(negedge clk); new_req = '0;
    for (int g = 0; g < 100 && !done; g++) begin
      @(negedge clk);
      checks++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL up3_cycle t=%0t dut=%b want=%b", $time, obs_v, exp_v); end
      mu += int'(moving_up); dn += int'(door_open); cl += int'(clear_current_request);
      if (dn > 0 && !door_open) done = 1;
    end
    checks++; if (!done) begin fails++; $display("FAIL up3_timeout dut=%b want=door cycle completed", obs_v); end
    checks++; if (mu != 12) begin fails++; $display("FAIL up3_move_cycles got=%0d want=12", mu); end
    checks++; if (dn != 6) begin fails++; $display("FAIL up3_door_cycles got=%0d want=6", dn); end
    checks++; if (cl != 6) begin fails++; $display("FAIL up3_clear_cycles got=%0d want=6", cl); end
    checks++; if (current_floor !== 4'd3) begin fails++; $display("FAIL up3_floor got=%0d want=3", current_floor); end
    checks++; if (req_q !== '0) begin fails++; $display("FAIL up3_bit_cleared got=%b want=0", req_q); end
  endtask

  task automatic test_reverse();
    int order[$];
    bit at5 = 0, done = 0, pd = 0, pu = 0, pdn = 0;
    new_req = 10'(1) << 7; @(negedge clk); new_req = '0;
    for (int g = 0; g < 100 && !at5; g++) begin
      @(negedge clk);
      checks++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL rev_approach t=%0t dut=%b want=%b", $time, obs_v, exp_v); end
      if (current_floor == 4'd5 && moving_up) at5 = 1;
    end
    checks++; if (!at5) begin fails++; $display("FAIL rev_reach5 floor=%0d want=5 moving up", current_floor); end
    new_req = 10'(1) << 2;
    for (int g = 0; g < 400 && !done; g++) begin
      @(negedge clk);
      new_req = '0;
      checks++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL rev_cycle t=%0t dut=%b want=%b", $time, obs_v, exp_v); end
      if (door_open && !pd) order.push_back(int'(current_floor));
      if ((pu && moving_down) || (pdn && moving_up))
        begin fails++; $display("FAIL rev_midfloor_reversal floor=%0d want=stop first", current_floor); end
      pd = door_open; pu = moving_up; pdn = moving_down;
      if (!moving_up && !moving_down && !door_open && req_q == '0) done = 1;
    end
    checks++;
    if (order.size() != 2) begin fails++; $display("FAIL rev_stops got=%0d want=2", order.size()); end
    else begin
      checks++; if (order[0] != 7) begin fails++; $display("FAIL rev_first got=%0d want=7", order[0]); end
      checks++; if (order[1] != 2) begin fails++; $display("FAIL rev_second got=%0d want=2", order[1]); end
    end
  endtask

  task automatic test_request_here();
    bit done = 0;
    new_req = 10'(1) << 4; @(negedge clk); new_req = '0;
    for (int g = 0; g < 200 && !done; g++) begin
      @(negedge clk);
      checks++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL here_travel t=%0t dut=%b want=%b", $time, obs_v, exp_v); end
      if (!moving_up && !moving_down && !door_open && req_q == '0) done = 1;
    end
    checks++; if (current_floor !== 4'd4) begin fails++; $display("FAIL here_at4 got=%0d want=4", current_floor); end
    new_req = 10'(1) << 4; @(negedge clk); new_req = '0;
    checks++;
    if (door_open !== 1'b0 || req_q[4] !== 1'b1) begin fails++; $display("FAIL here_latched door=%b req=%b want door=0 req=1", door_open, req_q[4]); end
    @(negedge clk);
    checks++;
    if ({door_open, moving_up, moving_down} !== 3'b100)
      begin fails++; $display("FAIL here_door_next got=%b want=100", {door_open, moving_up, moving_down}); end
    for (int g = 0; g < 20 && door_open; g++) begin
      @(negedge clk);
      checks++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL here_door t=%0t dut=%b want=%b", $time, obs_v, exp_v); end
    end
    checks++; if (req_q[4] !== 1'b0 || door_open) begin fails++; $display("FAIL here_cleared req=%b door=%b want 0 0", req_q[4], door_open); end
  endtask

  task automatic test_door_hold();
    int n = 0;
    new_req = 10'(1) << 4; @(negedge clk); new_req = '0;
    for (int g = 0; g < 20 && !door_open; g++) @(negedge clk);
    checks++; if (!door_open) begin fails++; $display("FAIL hold_open got=%b want=1", door_open); end
    door_hold = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (door_open !== 1'b1 || obs_v !== exp_v) begin fails++; $display("FAIL hold_stays c=%0d dut=%b want=%b", c, obs_v, exp_v); end
    end
    door_hold = 1'b0;
    for (int g = 0; g < 50 && door_open; g++) begin
      n++;
      @(negedge clk);
      checks++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL hold_release t=%0t dut=%b want=%b", $time, obs_v, exp_v); end
    end
    checks++; if (n != DC) begin fails++; $display("FAIL hold_close_delay got=%0d want=%0d", n, DC); end
  endtask

  task automatic test_extremes();
    int tgt;
    bit done;
    for (int k = 0; k < 2; k++) begin
      tgt = (k == 0) ? NF - 1 : 0;
      done = 0;
      new_req = 10'(1) << tgt; @(negedge clk); new_req = '0;
      for (int g = 0; g < 300 && !done; g++) begin
        @(negedge clk);
        checks++;
        if (obs_v !== exp_v) begin fails++; $display("FAIL extreme_cycle t=%0t dut=%b want=%b", $time, obs_v, exp_v); end
        if (!moving_up && !moving_down && !door_open && req_q == '0) done = 1;
      end
      checks++; if (int'(current_floor) != tgt) begin fails++; $display("FAIL extreme_floor got=%0d want=%0d", current_floor, tgt); end
    end
  endtask

  task automatic test_reset_mid_travel();
    bit at2 = 0;
    new_req = 10'(1) << 5; @(negedge clk); new_req = '0;
    for (int g = 0; g < 100 && !at2; g++) begin
      @(negedge clk);
      if (current_floor == 4'd2 && moving_up) at2 = 1;
    end
    checks++; if (!at2) begin fails++; $display("FAIL rstmid_reach2 floor=%0d want=2 moving up", current_floor); end
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (obs_v !== IDLE_FLOOR0 || obs_v !== exp_v) begin fails++; $display("FAIL rstmid_async dut=%b want=%b", obs_v, IDLE_FLOOR0); end
    @(negedge clk) reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (obs_v !== IDLE_FLOOR0) begin fails++; $display("FAIL rstmid_release c=%0d dut=%b want=%b", c, obs_v, IDLE_FLOOR0); end
    end
  endtask

  task automatic test_random();
    bit done = 0;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      checks++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL rand_cycle c=%0d dut=%b want=%b", c, obs_v, exp_v); end
      new_req   = ($urandom_range(0, 5) == 0) ? (10'(1) << $urandom_range(0, NF - 1)) : '0;
      door_hold = ($urandom_range(0, 11) == 0);
    end
    new_req = '0; door_hold = 1'b0;
    for (int g = 0; g < 1000 && !done; g++) begin
      @(negedge clk);
      checks++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL rand_drain t=%0t dut=%b want=%b", $time, obs_v, exp_v); end
      if (!moving_up && !moving_down && !door_open && req_q == '0) done = 1;
    end
    checks++; if (!done) begin fails++; $display("FAIL rand_drain_timeout req=%b want all serviced", req_q); end
  endtask

  initial begin
    test_reset();
    test_up_to_3();
    test_reverse();
    test_request_here();
    test_door_hold();
    test_extremes();
    test_reset_mid_travel();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
